// File: rtl/traffic_light_monitor.sv
// Passive lamp checker for the traffic light controller: decodes phase,
// tracks dwell and rounds, and latches the first timing/order fault.
module traffic_light_monitor #(
  parameter int MIN_GREEN_A = 6,
  parameter int MIN_GREEN_B = 5,
  parameter int YELLOW_LEN  = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Ra,
  input  logic             Ya,
  input  logic             Ga,
  input  logic             Rb,
  input  logic             Yb,
  input  logic             Gb,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] rounds,
  output logic             fault,
  output logic [2:0]       fault_code
);

  typedef enum logic {
    S_INIT,
    S_TRACK
  } state_t;

  localparam logic [1:0] P_AG = 2'd0;
  localparam logic [1:0] P_BG = 2'd2;
  localparam logic [1:0] P_BY = 2'd3;

  localparam logic [CNT_W-1:0] MGA = CNT_W'(MIN_GREEN_A);
  localparam logic [CNT_W-1:0] MGB = CNT_W'(MIN_GREEN_B);
  localparam logic [CNT_W-1:0] YL  = CNT_W'(YELLOW_LEN);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] rounds_q, rounds_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic             entry_q, entry_d;
  logic             yflag_q, yflag_d;

  logic [5:0] lamps;
  logic       legal;
  logic [1:0] dec;
  logic [2:0] hit;
  logic       order_ok;
  logic       is_yel;

  assign lamps  = {Ra, Ya, Ga, Rb, Yb, Gb};
  assign is_yel = phase_q[0];

  always_comb begin
    legal = 1'b1;
    dec   = 2'd0;
    case (lamps)
      6'b001100: dec = 2'd0;
      6'b010100: dec = 2'd1;
      6'b100001: dec = 2'd2;
      6'b100010: dec = 2'd3;
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dwell_d  = dwell_q;
    rounds_d = rounds_q;
    entry_d  = entry_q;
    yflag_d  = yflag_q;
    fault_d  = fault_q;
    code_d   = code_q;
    hit      = 3'd0;
    order_ok = 1'b0;
    unique case (state_q)
      S_INIT: begin
        if (!legal) begin
          hit = 3'd1;
        end else begin
          state_d = S_TRACK;
          phase_d = dec;
          dwell_d = ONE;
          entry_d = 1'b1;
          yflag_d = 1'b0;
        end
      end
      S_TRACK: begin
        if (!legal) begin
          hit     = 3'd1;
          state_d = S_INIT;
        end else if (dec == phase_q) begin
          if (dwell_q != '1) dwell_d = dwell_q + ONE;
          // Yellow overstay is reported as soon as it is seen, once per visit
          if (is_yel && !entry_q && !yflag_q && dwell_q >= YL) begin
            hit     = 3'd5;
            yflag_d = 1'b1;
          end
        end else begin
          order_ok = (dec == phase_q + 2'd1);
          if (!order_ok)
            hit = 3'd2;
          else if (!entry_q && phase_q == P_AG && dwell_q < MGA)
            hit = 3'd3;
          else if (!entry_q && phase_q == P_BG && dwell_q < MGB)
            hit = 3'd4;
          else if (!entry_q && is_yel && !yflag_q && dwell_q != YL)
            hit = 3'd5;
          if (order_ok && phase_q == P_BY) rounds_d = rounds_q + ONE;
          phase_d = dec;
          dwell_d = ONE;
          entry_d = 1'b0;
          yflag_d = 1'b0;
        end
      end
    endcase
    if (hit != 3'd0 && (!fault_q || clear)) begin
      fault_d = 1'b1;
      code_d  = hit;
    end else if (clear) begin
      fault_d = 1'b0;
      code_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_INIT;
      phase_q  <= 2'd0;
      dwell_q  <= '0;
      rounds_q <= '0;
      fault_q  <= 1'b0;
      code_q   <= 3'd0;
      entry_q  <= 1'b0;
      yflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      rounds_q <= rounds_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      entry_q  <= entry_d;
      yflag_q  <= yflag_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = (state_q == S_TRACK);
  assign dwell       = dwell_q;
  assign rounds      = rounds_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed lamp sequences
// push expected outputs; a monitor pops and compares after each edge.
module tb_traffic_light_monitor;

  localparam logic [5:0] AG  = 6'b001100;
  localparam logic [5:0] AY  = 6'b010100;
  localparam logic [5:0] BG  = 6'b100001;
  localparam logic [5:0] BY  = 6'b100010;
  localparam logic [5:0] BAD = 6'b001001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Ra = 1'b0, Ya = 1'b0, Ga = 1'b0;
  logic       Rb = 1'b0, Yb = 1'b0, Gb = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] phase;
  logic       phase_valid;
  logic [7:0] dwell;
  logic [7:0] rounds;
  logic       fault;
  logic [2:0] fault_code;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset),
    .Ra(Ra), .Ya(Ya), .Ga(Ga),
    .Rb(Rb), .Yb(Yb), .Gb(Gb),
    .clear(clear),
    .phase(phase), .phase_valid(phase_valid),
    .dwell(dwell), .rounds(rounds),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    bit         chk;
    logic [1:0] ph;
    logic       v;
    logic [7:0] dw;
    logic [7:0] rd;
    logic       f;
    logic [2:0] fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  task automatic cmp(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_all(input exp_t e);
    cmp({e.nm, ".phase"}, 8'(phase), 8'(e.ph));
    cmp({e.nm, ".valid"}, 8'(phase_valid), 8'(e.v));
    cmp({e.nm, ".dwell"}, dwell, e.dw);
    cmp({e.nm, ".rounds"}, rounds, e.rd);
    cmp({e.nm, ".fault"}, 8'(fault), 8'(e.f));
    cmp({e.nm, ".code"}, 8'(fault_code), 8'(e.fc));
  endtask

  task automatic apply(input logic [5:0] l, input bit c, input bit chk,
                       input logic [1:0] ph, input logic v, input int dw,
                       input int rd, input logic f, input logic [2:0] fc,
                       input string nm);
    exp_t e;
    reset = 1'b0;
    {Ra, Ya, Ga, Rb, Yb, Gb} = l;
    clear = c;
    e.nm = nm; e.chk = chk; e.ph = ph; e.v = v;
    e.dw = 8'(dw); e.rd = 8'(rd); e.f = f; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic step(input logic [5:0] l, input bit c, input int n,
                      input logic [1:0] ph, input logic v, input int dw,
                      input int rd, input logic f, input logic [2:0] fc,
                      input string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      apply(l, c, (i == n - 1), ph, v, dw, rd, f, fc, nm);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {Ra, Ya, Ga, Rb, Yb, Gb} = 6'b0;
    clear = 1'b0;
  endtask

  task automatic prefix_round();
    step(AG, 0, 6, 0, 1, 6, 0, 0, 0, "pre_ag");
    step(AY, 0, 1, 1, 1, 1, 0, 0, 0, "pre_ay");
    step(BG, 0, 5, 2, 1, 5, 0, 0, 0, "pre_bg");
    step(BY, 0, 1, 3, 1, 1, 0, 0, 0, "pre_by");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) check_all(e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    exp_t z;
    z.nm = "reset0"; z.chk = 1; z.ph = 0; z.v = 0;
    z.dw = 0; z.rd = 0; z.f = 0; z.fc = 0;
    @(posedge clk);
    #1;
    check_all(z);

    step(AG, 0, 1, 0, 1, 1, 0, 0, 0, "s1_ag1");
    step(AG, 0, 5, 0, 1, 6, 0, 0, 0, "s1_ag6");
    step(AY, 0, 1, 1, 1, 1, 0, 0, 0, "s1_ay");
    step(BG, 0, 5, 2, 1, 5, 0, 0, 0, "s1_bg");
    step(BY, 0, 1, 3, 1, 1, 0, 0, 0, "s1_by");
    step(AG, 0, 1, 0, 1, 1, 1, 0, 0, "s1_round");

    step(BAD, 0, 1, 0, 0, 1, 1, 1, 1, "s2_illegal");
    step(AG, 0, 1, 0, 1, 1, 1, 1, 1, "s2_resync");

    do_reset();
    step(AG, 0, 1, 0, 1, 1, 0, 0, 0, "s3_entry");
    step(AY, 0, 1, 1, 1, 1, 0, 0, 0, "s3_ay");
    step(BG, 0, 5, 2, 1, 5, 0, 0, 0, "s3_bg");
    step(BY, 0, 1, 3, 1, 1, 0, 0, 0, "s3_by");
    step(AG, 0, 6, 0, 1, 6, 1, 0, 0, "s3_ag");
    step(BG, 0, 1, 2, 1, 1, 1, 1, 2, "s3_order");

    do_reset();
    prefix_round();
    step(AG, 0, 4, 0, 1, 4, 1, 0, 0, "s4_ag4");
    step(AY, 0, 1, 1, 1, 1, 1, 1, 3, "s4_shortA");

    do_reset();
    step(AG, 0, 6, 0, 1, 6, 0, 0, 0, "s4b_ag");
    step(AY, 0, 1, 1, 1, 1, 0, 0, 0, "s4b_ay");
    step(BG, 0, 3, 2, 1, 3, 0, 0, 0, "s4b_bg3");
    step(BY, 0, 1, 3, 1, 1, 0, 1, 4, "s4b_shortB");

    do_reset();
    prefix_round();
    step(AG, 0, 6, 0, 1, 6, 1, 0, 0, "s5_ag");
    step(AY, 0, 1, 1, 1, 1, 1, 0, 0, "s5_ay1");
    step(AY, 0, 1, 1, 1, 2, 1, 1, 5, "s5_ay2");
    step(BG, 1, 1, 2, 1, 1, 1, 0, 0, "s5_clear");
    step(BAD, 1, 1, 2, 0, 1, 1, 1, 1, "s5_clr_hit");

    do_reset();
    step(AG, 0, 6, 0, 1, 6, 0, 0, 0, "s6_ag");
    step(AY, 0, 1, 1, 1, 1, 0, 0, 0, "s6_ay");
    step(BG, 0, 3, 2, 1, 3, 0, 0, 0, "s6_bg3");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    z.nm = "s6_async";
    check_all(z);
    step(BY, 0, 1, 3, 1, 1, 0, 0, 0, "s6_entry");

    @(negedge clk);
    @(negedge clk);
    cmp("drain", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
